// File: rtl/issue_pkg.sv
// issue_pkg: entry layout and CDB wakeup helper shared by the issue queues
package issue_pkg;
  localparam int TAG_W = 6;
  localparam int DATA_W = 32;
  typedef struct packed {
    logic valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [TAG_W-1:0] rs1_tag;
    logic rs1_valid;
    logic [DATA_W-1:0] rs2_data;
    logic [TAG_W-1:0] rs2_tag;
    logic rs2_valid;
    logic [TAG_W:0] rd_token;
  } iq_entry_t;
  localparam iq_entry_t EMPTY = '0;
  function automatic iq_entry_t wakeup(iq_entry_t e, logic cdb_valid, logic [TAG_W-1:0] cdb_tag,
                                       logic [DATA_W-1:0] cdb_data);
    iq_entry_t r;
    r = e;
    if (e.valid && cdb_valid && !e.rs1_valid && e.rs1_tag == cdb_tag) begin
      r.rs1_data = cdb_data;
      r.rs1_valid = 1'b1;
    end
    if (e.valid && cdb_valid && !e.rs2_valid && e.rs2_tag == cdb_tag) begin
      r.rs2_data = cdb_data;
      r.rs2_valid = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: dispatch, CDB and ALU issue signals of the integer issue queue
interface int_issue_queue_if;
  import issue_pkg::*;
  logic int_queue_en;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [DATA_W-1:0] disp_imm;
  logic [DATA_W-1:0] disp_pc;
  logic [DATA_W-1:0] rs1_data;
  logic rs1_data_valid;
  logic [TAG_W-1:0] rs1_tag;
  logic [DATA_W-1:0] rs2_data;
  logic rs2_data_valid;
  logic [TAG_W-1:0] rs2_tag;
  logic [TAG_W:0] rd_token;
  logic queue_full;
  logic cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic issue_valid;
  logic issue_ready;
  logic [6:0] issue_opcode;
  logic [2:0] issue_funct3;
  logic [6:0] issue_funct7;
  logic [DATA_W-1:0] issue_imm;
  logic [DATA_W-1:0] issue_pc;
  logic [DATA_W-1:0] issue_rs1_data;
  logic [DATA_W-1:0] issue_rs2_data;
  logic [TAG_W:0] issue_rd_token;
  modport slave (
    input int_queue_en, opcode, funct3, funct7, disp_imm, disp_pc,
          rs1_data, rs1_data_valid, rs1_tag, rs2_data, rs2_data_valid, rs2_tag, rd_token,
          cdb_valid, cdb_tag, cdb_data, issue_ready,
    output queue_full, issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_imm,
           issue_pc, issue_rs1_data, issue_rs2_data, issue_rd_token
  );
  modport master (
    output int_queue_en, opcode, funct3, funct7, disp_imm, disp_pc,
           rs1_data, rs1_data_valid, rs1_tag, rs2_data, rs2_data_valid, rs2_tag, rd_token,
           cdb_valid, cdb_tag, cdb_data, issue_ready,
    input queue_full, issue_valid, issue_opcode, issue_funct3, issue_funct7, issue_imm,
          issue_pc, issue_rs1_data, issue_rs2_data, issue_rd_token
  );
endinterface

// File: rtl/iq_select.sv
// iq_select: one-hot pick of the lowest-index (oldest) ready slot
module iq_select #(
  parameter int N = 4
) (
  input  logic [N-1:0] ready,
  output logic [N-1:0] sel,
  output logic         any_ready
);
  assign sel = ready & (~ready + N'(1));
  assign any_ready = |ready;
endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: age-ordered, shift-compacting integer reservation station
module int_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  int_issue_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  iq_entry_t q [DEPTH];
  iq_entry_t w [DEPTH];
  iq_entry_t nxt [DEPTH];
  iq_entry_t inc;
  logic [CW-1:0] count, count_nxt, pos;
  logic [DEPTH-1:0] ready, sel, shift;
  logic full_q, any, fire, enq;
  // a slot is ready once both operands are present
  always_comb for (int i = 0; i < DEPTH; i++) ready[i] = q[i].valid & q[i].rs1_valid & q[i].rs2_valid;
  iq_select #(.N(DEPTH)) u_select (.ready(ready), .sel(sel), .any_ready(any));
  assign fire = any & bus.issue_ready;
  assign enq = bus.int_queue_en & ~full_q;
  assign shift = fire ? ~(sel - DEPTH'(1)) : '0;
  assign pos = count - CW'(fire);
  assign count_nxt = count + CW'(enq) - CW'(fire);
  assign bus.queue_full = full_q;
  assign bus.issue_valid = any;
  // present the selected slot, all zero when nothing is ready
  always_comb begin
    bus.issue_opcode = '0;
    bus.issue_funct3 = '0;
    bus.issue_funct7 = '0;
    bus.issue_imm = '0;
    bus.issue_pc = '0;
    bus.issue_rs1_data = '0;
    bus.issue_rs2_data = '0;
    bus.issue_rd_token = '0;
    for (int i = 0; i < DEPTH; i++) if (sel[i]) begin
      bus.issue_opcode = q[i].opcode;
      bus.issue_funct3 = q[i].funct3;
      bus.issue_funct7 = q[i].funct7;
      bus.issue_imm = q[i].imm;
      bus.issue_pc = q[i].pc;
      bus.issue_rs1_data = q[i].rs1_data;
      bus.issue_rs2_data = q[i].rs2_data;
      bus.issue_rd_token = q[i].rd_token;
    end
  end
  // incoming entry, snooping the CDB in its own enqueue cycle
  always_comb begin
    inc = '{valid: 1'b1, opcode: bus.opcode, funct3: bus.funct3, funct7: bus.funct7,
            imm: bus.disp_imm, pc: bus.disp_pc,
            rs1_data: bus.rs1_data, rs1_tag: bus.rs1_tag, rs1_valid: bus.rs1_data_valid,
            rs2_data: bus.rs2_data, rs2_tag: bus.rs2_tag, rs2_valid: bus.rs2_data_valid,
            rd_token: bus.rd_token};
    inc = wakeup(inc, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
  end
  // wake every slot, squeeze out the fired one and drop the new entry at the tail
  always_comb begin
    for (int i = 0; i < DEPTH; i++) w[i] = wakeup(q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    for (int i = 0; i < DEPTH; i++) begin
      nxt[i] = shift[i] ? ((i == DEPTH - 1) ? EMPTY : w[(i + 1) % DEPTH]) : w[i];
      if (enq && pos == CW'(i)) nxt[i] = inc;
    end
  end
  // slot storage, occupancy and the registered full flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '{default: EMPTY};
      count <= '0;
      full_q <= 1'b0;
    end else begin
      q <= nxt;
      count <= count_nxt;
      full_q <= count_nxt == CW'(DEPTH);
    end
  end
  a_no_enq_when_full: assert property (@(posedge clk) disable iff (!rst) !(bus.int_queue_en && full_q))
    else $warning("int_issue_queue: enqueue dropped while queue_full");
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: directed vectors and hand sequences for int_issue_queue
module tb_int_issue_queue;
  import issue_pkg::*;
  typedef struct {
    logic en;
    logic r1v; logic [5:0] r1t; logic [31:0] r1d;
    logic r2v; logic [5:0] r2t; logic [31:0] r2d;
    logic [6:0] tok;
    logic cv; logic [5:0] ct; logic [31:0] cd;
    logic rdy;
    logic ev; logic [31:0] e1; logic [31:0] e2; logic [6:0] etok; logic efull;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int applied = 0;
  int miscompares = 0;
  vec_t tbl [8];
  always #5 clk = ~clk;
  int_issue_queue_if bus();
  int_issue_queue #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  function automatic logic [31:0] pc_of(logic [6:0] t);
    return 32'h1000 + {23'd0, t, 2'b00};
  endfunction
  function automatic logic [31:0] imm_of(logic [6:0] t);
    return 32'hFFFF_0000 | {25'd0, t};
  endfunction
  function automatic logic [16:0] dec_of(logic [6:0] t);
    return {t ^ 7'h33, t[2:0], t[0], t[6:1]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic r1v, input logic [5:0] r1t, input logic [31:0] r1d,
                       input logic r2v, input logic [5:0] r2t, input logic [31:0] r2d, input logic [6:0] tok,
                       input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic rdy);
    bus.int_queue_en = en;
    bus.rs1_data_valid = r1v; bus.rs1_tag = r1t; bus.rs1_data = r1d;
    bus.rs2_data_valid = r2v; bus.rs2_tag = r2t; bus.rs2_data = r2d;
    bus.rd_token = tok;
    {bus.opcode, bus.funct3, bus.funct7} = dec_of(tok);
    bus.disp_pc = pc_of(tok);
    bus.disp_imm = imm_of(tok);
    bus.cdb_valid = cv; bus.cdb_tag = ct; bus.cdb_data = cd;
    bus.issue_ready = rdy;
  endtask

  task automatic idle(input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic rdy);
    drive(1'b0, 1'b0, 6'd0, 32'd0, 1'b0, 6'd0, 32'd0, 7'd0, cv, ct, cd, rdy);
  endtask

  task automatic expect_out(input string nm, input logic v, input logic [31:0] r1, input logic [31:0] r2,
                            input logic [6:0] tok);
    chk({nm, ".valid"}, {31'd0, bus.issue_valid}, {31'd0, v});
    chk({nm, ".rs1"}, bus.issue_rs1_data, v ? r1 : 32'd0);
    chk({nm, ".rs2"}, bus.issue_rs2_data, v ? r2 : 32'd0);
    chk({nm, ".token"}, {25'd0, bus.issue_rd_token}, v ? {25'd0, tok} : 32'd0);
    chk({nm, ".pc"}, bus.issue_pc, v ? pc_of(tok) : 32'd0);
    chk({nm, ".imm"}, bus.issue_imm, v ? imm_of(tok) : 32'd0);
    chk({nm, ".dec"}, {15'd0, bus.issue_opcode, bus.issue_funct3, bus.issue_funct7},
        v ? {15'd0, dec_of(tok)} : 32'd0);
  endtask

  task automatic chk_full(input string nm, input logic f);
    chk({nm, ".full"}, {31'd0, bus.queue_full}, {31'd0, f});
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{1, 1, 0, 5, 1, 0, 7, 7'h45, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 5, 7, 7'h45, 0};
    tbl[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[3] = '{1, 0, 3, 0, 1, 0, 2, 7'h41, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[4] = '{1, 1, 0, 10, 1, 0, 20, 7'h42, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 32'hDEAD, 1,  1, 10, 20, 7'h42, 0};
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 32'hDEAD, 2, 7'h41, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0};
    idle(1'b0, 6'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    expect_out("reset", 1'b0, 32'd0, 32'd0, 7'd0);
    chk_full("reset", 1'b0);
    rst = 1'b1;
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].en, tbl[i].r1v, tbl[i].r1t, tbl[i].r1d, tbl[i].r2v, tbl[i].r2t, tbl[i].r2d, tbl[i].tok,
            tbl[i].cv, tbl[i].ct, tbl[i].cd, tbl[i].rdy);
      #1;
      expect_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].e1, tbl[i].e2, tbl[i].etok);
      chk_full($sformatf("vec%0d", i), tbl[i].efull);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 6'(10 + i), 32'd0, 1'b1, 6'd0, 32'h100 + i, 7'(8'h50 + i), 1'b0, 6'd0, 32'd0, 1'b0);
      #1;
      chk_full($sformatf("fill%0d", i), 1'b0);
      cycle();
    end
    drive(1'b1, 1'b1, 6'd0, 32'd1, 1'b1, 6'd0, 32'd2, 7'h5F, 1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    chk_full("full4", 1'b1);
    expect_out("full4", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    idle(1'b1, 6'd12, 32'h222, 1'b0);
    #1;
    chk_full("dropped", 1'b1);
    expect_out("dropped", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    drive(1'b1, 1'b1, 6'd0, 32'h77, 1'b1, 6'd0, 32'h78, 7'h5E, 1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("wake2", 1'b1, 32'h222, 32'h102, 7'h52);
    chk_full("wake2", 1'b1);
    cycle();
    idle(1'b1, 6'd13, 32'h333, 1'b0);
    #1;
    chk_full("after_fire", 1'b0);
    expect_out("no_bypass", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    idle(1'b1, 6'd10, 32'h111, 1'b0);
    #1;
    expect_out("shifted", 1'b1, 32'h333, 32'h103, 7'h53);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("oldest", 1'b1, 32'h111, 32'h100, 7'h50);
    cycle();
    #1;
    expect_out("next", 1'b1, 32'h333, 32'h103, 7'h53);
    cycle();
    idle(1'b1, 6'd11, 32'h444, 1'b1);
    #1;
    expect_out("pending", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("last", 1'b1, 32'h444, 32'h101, 7'h51);
    cycle();
    #1;
    expect_out("drained", 1'b0, 32'd0, 32'd0, 7'd0);
    drive(1'b1, 1'b0, 6'd9, 32'd0, 1'b1, 6'd0, 32'h5, 7'h39, 1'b1, 6'd9, 32'h99, 1'b1);
    #1;
    expect_out("enq_wake", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("enq_woken", 1'b1, 32'h99, 32'h5, 7'h39);
    cycle();
    #1;
    expect_out("enq_gone", 1'b0, 32'd0, 32'd0, 7'd0);
    drive(1'b1, 1'b1, 6'd0, 32'hA1, 1'b1, 6'd0, 32'hA2, 7'h61, 1'b0, 6'd0, 32'd0, 1'b0);
    cycle();
    drive(1'b1, 1'b0, 6'd20, 32'd0, 1'b1, 6'd0, 32'hB2, 7'h62, 1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    expect_out("c2_x", 1'b1, 32'hA1, 32'hA2, 7'h61);
    cycle();
    drive(1'b1, 1'b0, 6'd21, 32'd0, 1'b1, 6'd0, 32'hC2, 7'h63, 1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("c2_fire", 1'b1, 32'hA1, 32'hA2, 7'h61);
    chk_full("c2_fire", 1'b0);
    cycle();
    drive(1'b1, 1'b0, 6'd30, 32'd0, 1'b1, 6'd0, 32'd0, 7'h64, 1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    expect_out("c2_after", 1'b0, 32'd0, 32'd0, 7'd0);
    chk_full("c2_after", 1'b0);
    cycle();
    drive(1'b1, 1'b0, 6'd31, 32'd0, 1'b1, 6'd0, 32'd0, 7'h65, 1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    chk_full("c2_three", 1'b0);
    cycle();
    idle(1'b1, 6'd21, 32'hC1, 1'b0);
    #1;
    chk_full("c2_four", 1'b1);
    cycle();
    idle(1'b1, 6'd20, 32'hB1, 1'b0);
    #1;
    expect_out("c2_z", 1'b1, 32'hC1, 32'hC2, 7'h63);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("c2_y_first", 1'b1, 32'hB1, 32'hB2, 7'h62);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b0);
    #1;
    expect_out("held3", 1'b1, 32'hC1, 32'hC2, 7'h63);
    #1 rst = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, 32'd0, 32'd0, 7'd0);
    chk_full("async_rst", 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b1, 6'd0, 32'hD1, 1'b1, 6'd0, 32'hD2, 7'h70, 1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("post_rst", 1'b0, 32'd0, 32'd0, 7'd0);
    cycle();
    idle(1'b0, 6'd0, 32'd0, 1'b1);
    #1;
    expect_out("post_issue", 1'b1, 32'hD1, 32'hD2, 7'h70);
    cycle();
    #1;
    expect_out("post_empty", 1'b0, 32'd0, 32'd0, 7'd0);
    chk_full("post_empty", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
